// File: rtl/serial_twos_comp.sv
// Bit-serial pass / ones' / two's complementer. A word is loaded on start and
// emitted LSB first; the parallel result, done, ovf and zero follow the last bit.
module serial_twos_comp #(
  parameter int unsigned N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [N_BITS-1:0] din,
  output logic              busy,
  output logic              ser_out,
  output logic              ser_valid,
  output logic [N_BITS-1:0] dout,
  output logic              done,
  output logic              ovf,
  output logic              zero
);

  localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_TWOS = 2'b10;
  localparam logic [N_BITS-1:0] MIN_NEG = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q;
  logic [N_BITS-1:0]  shreg_q;
  logic [N_BITS-1:0]  acc_q;
  logic [1:0]         mode_q;
  logic               seen_q;
  logic               ovf_pend_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               ser_out_q;
  logic               ser_valid_q;
  logic [N_BITS-1:0]  dout_q;
  logic               done_q;
  logic               ovf_q;
  logic               zero_q;

  logic               cur_bit;
  logic [1:0]         cur_mode;
  logic               cur_seen;
  logic               res_bit;

  // Bit 0 is computed straight from the operand on the load edge so it appears
  // one cycle after start; later bits come from the shift register.
  always_comb begin
    cur_bit  = shreg_q[0];
    cur_mode = mode_q;
    cur_seen = seen_q;
    if (state_q == S_IDLE) begin
      cur_bit  = din[0];
      cur_mode = mode;
      cur_seen = 1'b0;
    end
    res_bit = cur_bit;
    if (cur_mode == MODE_ONES) begin
      res_bit = ~cur_bit;
    end else if ((cur_mode == MODE_TWOS) && cur_seen) begin
      res_bit = ~cur_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      mode_q      <= 2'b00;
      seen_q      <= 1'b0;
      ovf_pend_q  <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= S_SHIFT;
            shreg_q     <= din >> 1;
            mode_q      <= mode;
            seen_q      <= din[0];
            ovf_pend_q  <= (mode == MODE_TWOS) && (din == MIN_NEG);
            cnt_q       <= '0;
            acc_q       <= {res_bit, (N_BITS-1)'(0)};
            ser_out_q   <= res_bit;
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (cnt_q == CNT_W'(N_BITS - 1)) begin
            state_q     <= S_DONE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b1;
            dout_q      <= acc_q;
            ovf_q       <= ovf_pend_q;
            zero_q      <= (acc_q == '0);
          end else begin
            ser_out_q <= res_bit;
            acc_q     <= {res_bit, acc_q[N_BITS-1:1]};
            shreg_q   <= shreg_q >> 1;
            seen_q    <= seen_q | cur_bit;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign dout      = dout_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_twos_comp.sv
// Directed bench for serial_twos_comp: 8-bit word table, start flooding, mid-word
// reset, and 2-bit / 13-bit builds.
module tb_serial_twos_comp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start;
  logic [1:0] mode;
  logic [7:0] din;
  logic       busy, ser_out, ser_valid, done, ovf, zero;
  logic [7:0] dout;

  logic        start2, busy2, ser_out2, ser_valid2, done2, ovf2, zero2;
  logic [1:0]  din2, dout2;
  logic        start13, busy13, ser_out13, ser_valid13, done13, ovf13, zero13;
  logic [12:0] din13, dout13;

  serial_twos_comp #(.N_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .din(din),
    .busy(busy), .ser_out(ser_out), .ser_valid(ser_valid), .dout(dout),
    .done(done), .ovf(ovf), .zero(zero));

  serial_twos_comp #(.N_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(2'b10), .din(din2),
    .busy(busy2), .ser_out(ser_out2), .ser_valid(ser_valid2), .dout(dout2),
    .done(done2), .ovf(ovf2), .zero(zero2));

  serial_twos_comp #(.N_BITS(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .mode(2'b10), .din(din13),
    .busy(busy13), .ser_out(ser_out13), .ser_valid(ser_valid13), .dout(dout13),
    .done(done13), .ovf(ovf13), .zero(zero13));

  int total = 0;
  int bad = 0;
  logic [7:0] prev_dout;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ovf;
    logic       zero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent reference used only for the start-flooding sequence.
  function automatic logic [7:0] ref_result(input logic [1:0] m, input logic [7:0] d);
    case (m)
      2'b01:   ref_result = ~d;
      2'b10:   ref_result = 8'(-d);
      default: ref_result = d;
    endcase
  endfunction

  // Runs one 8-bit word from IDLE and checks every observable step.
  task automatic run_word(input vec_t v);
    logic [7:0] ser_word;
    int         vcnt;
    logic       stray;
    @(negedge clk);
    start = 1'b1; din = v.din; mode = v.mode;
    @(negedge clk);
    start = 1'b0; din = ~v.din; mode = ~v.mode;
    chk("first_busy_ovf_zero", {busy, ovf, zero}, 3'b100);
    chk("dout_held", dout, prev_dout);
    ser_word = '0; vcnt = 0; stray = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (ser_valid) vcnt++;
      if (done || !busy) stray = 1'b1;
      ser_word[k] = ser_out;
    end
    chk("ser_valid_count", vcnt, 8);
    chk("no_early_done", stray, 1'b0);
    chk("ser_word", ser_word, v.dout);
    @(negedge clk);
    chk("done_cycle_flags", {done, busy, ser_valid}, 3'b110);
    chk("dout", dout, v.dout);
    chk("ovf_zero", {ovf, zero}, {v.ovf, v.zero});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", {done, busy}, 2'b00);
    @(negedge clk);
    chk("start_in_done_ignored", {busy, ser_valid}, 2'b00);
    prev_dout = v.dout;
  endtask

  initial begin
    vec_t vecs[11];
    int   done_at2, done_at13;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_v;
    logic        exp_done;

    vecs[0]  = '{2'b10, 8'h06, 8'hFA, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 8'h80, 8'h80, 1'b1, 1'b0};
    vecs[5]  = '{2'b10, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{2'b10, 8'hFF, 8'h01, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 8'h80, 8'h7F, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 8'h80, 8'h80, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 8'hFF, 8'h00, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; mode = 2'b00; din = '0;
    start2 = 1'b0; din2 = '0; start13 = 1'b0; din13 = '0;
    prev_dout = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, ser_out, ser_valid, done, ovf, zero}, 6'b0);
    chk("reset_dout", dout, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_word(vecs[i]);

    // start held every cycle: only every 10th request is accepted.
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) begin
        exp_done = (c % 10) == 9;
        chk("flood_done", done, exp_done);
        if (exp_done) begin
          exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          chk("flood_dout", dout, exp_v);
        end
      end
      if (c < 30) begin
        start = 1'b1;
        din   = 8'(c * 37 + 5);
        mode  = 2'(c % 4);
        if (c % 10 == 0) exp_q.push_back(ref_result(mode, din));
        @(negedge clk);
      end
    end
    start = 1'b0;
    prev_dout = dout;
    @(negedge clk);
    chk("flood_idle", busy, 1'b0);

    // Reset while bit 4 is on the line aborts the word without done.
    start = 1'b1; din = 8'h5A; mode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("bit4_valid", ser_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {busy, ser_out, ser_valid, done, ovf, zero}, 6'b0);
    chk("abort_dout", dout, 8'h00);
    prev_dout = 8'h00;
    run_word(vecs[0]);

    // Narrow and wide builds: done must land N_BITS+1 cycles after start.
    @(negedge clk);
    start2 = 1'b1; din2 = 2'd1; start13 = 1'b1; din13 = 13'd1;
    done_at2 = -1; done_at13 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start2 = 1'b0; start13 = 1'b0;
      if (done2 && done_at2 < 0) begin
        done_at2 = c;
        chk("n2_dout", dout2, 2'b11);
      end
      if (done13 && done_at13 < 0) begin
        done_at13 = c;
        chk("n13_dout", dout13, 13'h1FFF);
      end
    end
    chk("n2_done_cycle", done_at2, 3);
    chk("n13_done_cycle", done_at13, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
